game_round_ctrl: RTL and testbench

Round and duck sequencer for the Duck Hunt gameplay phase. It sits directly upstream of the game control FSM: it runs only while `game_enable` is high, spawns ducks, counts shots, hits and escapes per round, and accumulates the score. When the player fails a round or clears the last one, it raises `game_finished`, which moves the control FSM to its game-over state. Its outputs also drive the duck sprite/motion logic and the HUD overlay.

---
 rtl/game_round_ctrl.sv | 179 +++++++++++++++++
 tb/tb_game_round_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_ctrl.sv
// Duck Hunt round/duck sequencer: spawns ducks, counts shots, hits and escapes,
// accumulates a saturating score and flags the end of the game.
module game_round_ctrl #(
    parameter int unsigned DUCK_TIMEOUT_CYCLES = 195_000_000,
    parameter int unsigned PAUSE_CYCLES        = 65_000_000,
    parameter int unsigned DUCKS_PER_ROUND     = 10,
    parameter int unsigned SHOTS_PER_DUCK      = 3,
    parameter int unsigned HITS_TO_PASS        = 6,
    parameter int unsigned MAX_ROUNDS          = 9,
    parameter int unsigned HIT_POINTS          = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_enable,
    input  logic        shot,
    input  logic        duck_hit,
    output logic        duck_spawn,
    output logic        duck_active,
    output logic        duck_flee,
    output logic        duck_dead,
    output logic [1:0]  shots_left,
    output logic [3:0]  duck_idx,
    output logic [3:0]  hits_in_round,
    output logic [3:0]  round_num,
    output logic [15:0] score,
    output logic        game_won,
    output logic        game_finished
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPAWN,
        ST_FLIGHT,
        ST_RESOLVE,
        ST_ROUND_END,
        ST_FINISHED
    } state_t;

    localparam logic [31:0] L_FLIGHT_LAST = 32'(DUCK_TIMEOUT_CYCLES - 1);
    localparam logic [31:0] L_PAUSE_LAST  = 32'(PAUSE_CYCLES - 1);
    localparam logic [1:0]  L_SHOTS       = 2'(SHOTS_PER_DUCK);
    localparam logic [3:0]  L_LAST_DUCK   = 4'(DUCKS_PER_ROUND - 1);
    localparam logic [3:0]  L_HITS_PASS   = 4'(HITS_TO_PASS);
    localparam logic [3:0]  L_MAX_ROUND   = 4'(MAX_ROUNDS);

    state_t      r_state;
    logic [31:0] r_timer;
    logic        w_flight_last;
    logic        w_pause_done;
    logic [15:0] w_score_hit;

    function automatic logic [15:0] sat_add_score(input logic [15:0] a);
        logic [16:0] sum;
        sum = {1'b0, a} + 17'(HIT_POINTS);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    assign w_flight_last = (r_timer == L_FLIGHT_LAST);
    assign w_pause_done  = (r_timer == L_PAUSE_LAST);
    assign w_score_hit   = sat_add_score(score);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            duck_spawn    <= 1'b0;
            duck_active   <= 1'b0;
            duck_flee     <= 1'b0;
            duck_dead     <= 1'b0;
            shots_left    <= '0;
            duck_idx      <= '0;
            hits_in_round <= '0;
            round_num     <= 4'd1;
            score         <= '0;
            game_won      <= 1'b0;
            game_finished <= 1'b0;
        end else begin
            duck_spawn <= 1'b0;
            // Losing game_enable mid-game drops every flag but keeps the counters for the HUD
            if (!game_enable && r_state != ST_IDLE) begin
                r_state       <= ST_IDLE;
                duck_active   <= 1'b0;
                duck_flee     <= 1'b0;
                duck_dead     <= 1'b0;
                game_won      <= 1'b0;
                game_finished <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (game_enable) begin
                            score         <= '0;
                            hits_in_round <= '0;
                            duck_idx      <= '0;
                            game_won      <= 1'b0;
                            round_num     <= 4'd1;
                            duck_spawn    <= 1'b1;
                            shots_left    <= L_SHOTS;
                            r_state       <= ST_SPAWN;
                        end
                    end
                    ST_SPAWN: begin
                        duck_active <= 1'b1;
                        r_timer     <= '0;
                        r_state     <= ST_FLIGHT;
                    end
                    ST_FLIGHT: begin
                        r_timer <= r_timer + 32'd1;
                        if (shot && duck_hit) begin
                            shots_left    <= shots_left - 2'd1;
                            hits_in_round <= hits_in_round + 4'd1;
                            score         <= w_score_hit;
                            duck_active   <= 1'b0;
                            duck_dead     <= 1'b1;
                            r_timer       <= '0;
                            r_state       <= ST_RESOLVE;
                        end else if (shot) begin
                            shots_left <= shots_left - 2'd1;
                            // A miss on the final timer cycle still lets the duck escape
                            if (shots_left == 2'd1 || w_flight_last) begin
                                duck_active <= 1'b0;
                                duck_flee   <= 1'b1;
                                r_timer     <= '0;
                                r_state     <= ST_RESOLVE;
                            end
                        end else if (w_flight_last) begin
                            duck_active <= 1'b0;
                            duck_flee   <= 1'b1;
                            r_timer     <= '0;
                            r_state     <= ST_RESOLVE;
                        end
                    end
                    ST_RESOLVE: begin
                        r_timer <= r_timer + 32'd1;
                        if (w_pause_done) begin
                            duck_flee <= 1'b0;
                            duck_dead <= 1'b0;
                            r_timer   <= '0;
                            if (duck_idx == L_LAST_DUCK) begin
                                r_state <= ST_ROUND_END;
                            end else begin
                                duck_idx   <= duck_idx + 4'd1;
                                duck_spawn <= 1'b1;
                                shots_left <= L_SHOTS;
                                r_state    <= ST_SPAWN;
                            end
                        end
                    end
                    ST_ROUND_END: begin
                        r_timer <= r_timer + 32'd1;
                        if (w_pause_done) begin
                            r_timer <= '0;
                            if (hits_in_round < L_HITS_PASS) begin
                                game_won      <= 1'b0;
                                game_finished <= 1'b1;
                                r_state       <= ST_FINISHED;
                            end else if (round_num == L_MAX_ROUND) begin
                                game_won      <= 1'b1;
                                game_finished <= 1'b1;
                                r_state       <= ST_FINISHED;
                            end else begin
                                round_num     <= round_num + 4'd1;
                                hits_in_round <= '0;
                                duck_idx      <= '0;
                                duck_spawn    <= 1'b1;
                                shots_left    <= L_SHOTS;
                                r_state       <= ST_SPAWN;
                            end
                        end
                    end
                    ST_FINISHED: begin
                        game_finished <= 1'b1;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl using the small test configuration
// (timeout 20, pause 4, 3 ducks, 3 shots, 2 hits to pass, 2 rounds).
module tb_game_round_ctrl;

    logic        clk;
    logic        rst;
    logic        game_enable;
    logic        shot;
    logic        duck_hit;
    logic        duck_spawn, duck_active, duck_flee, duck_dead;
    logic [1:0]  shots_left;
    logic [3:0]  duck_idx, hits_in_round, round_num;
    logic [15:0] score;
    logic        game_won, game_finished;

    logic        s_spawn, s_active, s_flee, s_dead, s_won, s_finished;
    logic [1:0]  s_shots;
    logic [3:0]  s_idx, s_hits, s_round;
    logic [15:0] s_score;

    int n_total = 0;
    int n_bad   = 0;
    int pts;
    int n_fl;

    game_round_ctrl #(
        .DUCK_TIMEOUT_CYCLES(20), .PAUSE_CYCLES(4), .DUCKS_PER_ROUND(3),
        .SHOTS_PER_DUCK(3), .HITS_TO_PASS(2), .MAX_ROUNDS(2), .HIT_POINTS(100)
    ) u_dut (
        .clk(clk), .rst(rst), .game_enable(game_enable), .shot(shot), .duck_hit(duck_hit),
        .duck_spawn(duck_spawn), .duck_active(duck_active), .duck_flee(duck_flee),
        .duck_dead(duck_dead), .shots_left(shots_left), .duck_idx(duck_idx),
        .hits_in_round(hits_in_round), .round_num(round_num), .score(score),
        .game_won(game_won), .game_finished(game_finished)
    );

    // Second instance with a large per-hit value to reach score saturation
    game_round_ctrl #(
        .DUCK_TIMEOUT_CYCLES(20), .PAUSE_CYCLES(4), .DUCKS_PER_ROUND(3),
        .SHOTS_PER_DUCK(3), .HITS_TO_PASS(2), .MAX_ROUNDS(2), .HIT_POINTS(40000)
    ) u_sat (
        .clk(clk), .rst(rst), .game_enable(game_enable), .shot(shot), .duck_hit(duck_hit),
        .duck_spawn(s_spawn), .duck_active(s_active), .duck_flee(s_flee),
        .duck_dead(s_dead), .shots_left(s_shots), .duck_idx(s_idx),
        .hits_in_round(s_hits), .round_num(s_round), .score(s_score),
        .game_won(s_won), .game_finished(s_finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic measure_flight(output int n);
        n = 0;
        while (duck_active === 1'b1 && n < 100) begin
            n++;
            step(1);
        end
    endtask

    task automatic fire(input logic hit);
        shot     = 1'b1;
        duck_hit = hit;
        step(1);
        shot     = 1'b0;
        duck_hit = 1'b0;
    endtask

    initial begin
        rst = 1'b1; game_enable = 1'b0; shot = 1'b0; duck_hit = 1'b0;
        step(2);
        chk("rst_active", duck_active, 0);
        chk("rst_finished", game_finished, 0);
        chk("rst_score", score, 0);
        chk("rst_round", round_num, 1);
        chk("rst_shots", shots_left, 0);
        chk("rst_idx", duck_idx, 0);
        rst = 1'b0;
        step(1);

        // 1: no shots, every duck escapes on timeout
        game_enable = 1'b1;
        step(1);
        chk("s1_spawn", duck_spawn, 1);
        chk("s1_shots_init", shots_left, 3);
        step(1);
        chk("s1_active", duck_active, 1);
        chk("s1_spawn_pulse", duck_spawn, 0);
        for (int d = 0; d < 3; d++) begin
            measure_flight(n_fl);
            chk("s1_flight_len", n_fl, 20);
            chk("s1_flee", duck_flee, 1);
            chk("s1_idx", duck_idx, d);
            if (d < 2) begin
                step(3);
                chk("s1_pause_flee", duck_flee, 1);
                chk("s1_pause_nospawn", duck_spawn, 0);
                step(1);
                chk("s1_respawn", duck_spawn, 1);
                chk("s1_flee_clr", duck_flee, 0);
                step(1);
            end else begin
                step(7);
                chk("s1_fin_early", game_finished, 0);
                step(1);
                chk("s1_finished", game_finished, 1);
                chk("s1_won", game_won, 0);
                chk("s1_score", score, 0);
                chk("s1_round", round_num, 1);
            end
        end
        game_enable = 1'b0;
        step(1);
        chk("s1_fin_fall", game_finished, 0);

        // 2: first-shot hit on every duck of both rounds
        game_enable = 1'b1;
        step(2);
        pts = 0;
        for (int r = 1; r <= 2; r++) begin
            for (int d = 0; d < 3; d++) begin
                chk("s2_active", duck_active, 1);
                fire(1'b1);
                pts += 100;
                chk("s2_dead", duck_dead, 1);
                chk("s2_inactive", duck_active, 0);
                chk("s2_shots", shots_left, 2);
                chk("s2_hits", hits_in_round, d + 1);
                chk("s2_score", score, pts);
                if (d < 2) begin
                    step(4);
                    chk("s2_spawn", duck_spawn, 1);
                    step(1);
                end else if (r == 1) begin
                    step(4);
                    chk("s2_re_hits", hits_in_round, 3);
                    chk("s2_re_idx", duck_idx, 2);
                    chk("s2_re_round", round_num, 1);
                    step(4);
                    chk("s2_r2_spawn", duck_spawn, 1);
                    chk("s2_r2_round", round_num, 2);
                    chk("s2_r2_hits", hits_in_round, 0);
                    chk("s2_r2_idx", duck_idx, 0);
                    step(1);
                end else begin
                    step(7);
                    chk("s2_fin_early", game_finished, 0);
                    step(1);
                    chk("s2_finished", game_finished, 1);
                    chk("s2_won", game_won, 1);
                    chk("s2_score_final", score, 600);
                    chk("s2_round_final", round_num, 2);
                end
            end
        end
        game_enable = 1'b0;
        step(1);

        // 3: three misses exhaust the duck; a shot during the pause is ignored
        game_enable = 1'b1;
        step(2);
        fire(1'b0);
        chk("s3_shots2", shots_left, 2);
        chk("s3_still_active", duck_active, 1);
        step(1);
        fire(1'b0);
        chk("s3_shots1", shots_left, 1);
        step(1);
        fire(1'b0);
        chk("s3_shots0", shots_left, 0);
        chk("s3_flee", duck_flee, 1);
        chk("s3_inactive", duck_active, 0);
        fire(1'b0);
        chk("s3_resolve_shots", shots_left, 0);
        chk("s3_resolve_flee", duck_flee, 1);
        chk("s3_resolve_hits", hits_in_round, 0);
        game_enable = 1'b0;
        step(1);

        // 4: stray duck_hit ignored, hit on final timer cycle counts
        game_enable = 1'b1;
        step(2);
        step(4);
        duck_hit = 1'b1;
        step(1);
        duck_hit = 1'b0;
        chk("s4_stray_hits", hits_in_round, 0);
        chk("s4_stray_shots", shots_left, 3);
        chk("s4_stray_active", duck_active, 1);
        step(14);
        chk("s4_last_cycle_active", duck_active, 1);
        fire(1'b1);
        chk("s4_dead", duck_dead, 1);
        chk("s4_no_flee", duck_flee, 0);
        chk("s4_hits", hits_in_round, 1);
        chk("s4_score", score, 100);
        game_enable = 1'b0;
        step(1);

        // 5: abort mid-flight, then restart
        game_enable = 1'b1;
        step(2);
        fire(1'b1);
        chk("s5_score_hit", score, 100);
        step(4);
        chk("s5_spawn", duck_spawn, 1);
        step(4);
        chk("s5_mid_active", duck_active, 1);
        game_enable = 1'b0;
        step(1);
        chk("s5_abort_active", duck_active, 0);
        chk("s5_abort_score", score, 100);
        step(2);
        chk("s5_idle_score", score, 100);
        chk("s5_idle_hits", hits_in_round, 1);
        chk("s5_idle_spawn", duck_spawn, 0);
        game_enable = 1'b1;
        step(1);
        chk("s5_restart_spawn", duck_spawn, 1);
        chk("s5_restart_score", score, 0);
        chk("s5_restart_round", round_num, 1);
        chk("s5_restart_hits", hits_in_round, 0);
        game_enable = 1'b0;
        step(1);

        // 6: saturation with 40000 points per hit
        game_enable = 1'b1;
        step(2);
        fire(1'b1);
        chk("s6_sat_first", s_score, 40000);
        chk("s6_dut_first", score, 100);
        step(4);
        step(1);
        chk("s6_active2", s_active, 1);
        fire(1'b1);
        chk("s6_sat_clamp", s_score, 16'hFFFF);
        chk("s6_sat_hits", s_hits, 2);
        chk("s6_dut_second", score, 200);
        game_enable = 1'b0;
        step(1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
